// File: rtl/mac_unit.sv
// Signed multiply-accumulate element for the matrix-multiply processing array.
// Optional registered product stage and optional saturating accumulator.
module mac_unit #(
    parameter int IN_WIDTH    = 8,
    parameter int ACC_WIDTH   = 32,
    parameter bit SATURATE    = 1'b0,
    parameter int PIPE_STAGES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [IN_WIDTH-1:0]  a,
    input  logic [IN_WIDTH-1:0]  b,
    output logic [ACC_WIDTH-1:0] acc
);

    localparam int PROD_WIDTH = 2 * IN_WIDTH;

    logic signed [PROD_WIDTH-1:0] a_ext;
    logic signed [PROD_WIDTH-1:0] b_ext;
    logic signed [PROD_WIDTH-1:0] prod_now;
    logic signed [ACC_WIDTH-1:0]  add_term;
    logic                         add_en;
    logic signed [ACC_WIDTH:0]    sum_wide;
    logic [ACC_WIDTH-1:0]         acc_next;

    // Operands are widened first so the multiply is full precision.
    assign a_ext    = PROD_WIDTH'($signed(a));
    assign b_ext    = PROD_WIDTH'($signed(b));
    assign prod_now = a_ext * b_ext;

    generate
        if (PIPE_STAGES == 1) begin : g_pipe
            logic signed [PROD_WIDTH-1:0] prod_reg;
            logic                         en_dly;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prod_reg <= '0;
                    en_dly   <= 1'b0;
                end else begin
                    prod_reg <= prod_now;
                    en_dly   <= enable;
                end
            end

            assign add_term = ACC_WIDTH'(prod_reg);
            assign add_en   = en_dly;
        end else begin : g_direct
            assign add_term = ACC_WIDTH'(prod_now);
            assign add_en   = enable;
        end
    endgenerate

    // One guard bit exposes signed overflow for the saturating variant.
    assign sum_wide = {acc[ACC_WIDTH-1], acc} + {add_term[ACC_WIDTH-1], add_term};

    always_comb begin
        acc_next = sum_wide[ACC_WIDTH-1:0];
        if (SATURATE && (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])) begin
            if (sum_wide[ACC_WIDTH])
                acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            else
                acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (add_en)
            acc <= acc_next;
    end

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: four configurations share one stimulus stream
// and are compared each cycle against an integer reference model.
module tb_mac_unit;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] acc0;
    logic [15:0] acc1;
    logic [15:0] acc2;
    logic [31:0] acc3;

    int tests;
    int failures;

    typedef struct {
        longint e0;
        longint e1;
        longint e2;
        longint e3;
    } exp_t;

    exp_t   scoreboard[$];
    longint m0, m1, m2, m3;
    longint pprod;
    bit     pen;

    mac_unit #(.IN_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1'b0), .PIPE_STAGES(0)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .a(a), .b(b), .acc(acc0));
    mac_unit #(.IN_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b0), .PIPE_STAGES(0)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .a(a), .b(b), .acc(acc1));
    mac_unit #(.IN_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b1), .PIPE_STAGES(0)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .a(a), .b(b), .acc(acc2));
    mac_unit #(.IN_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1'b0), .PIPE_STAGES(1)) u3 (
        .clk(clk), .reset(reset), .enable(enable), .a(a), .b(b), .acc(acc3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint fitAcc(longint v, int w, bit sat);
        longint maxv;
        longint minv;
        longint m;
        maxv = (longint'(1) <<< (w - 1)) - 1;
        minv = -(longint'(1) <<< (w - 1));
        if (sat) begin
            if (v > maxv) return maxv;
            if (v < minv) return minv;
            return v;
        end
        m = v & ((longint'(1) <<< w) - 1);
        if (m > maxv) m = m - (longint'(1) <<< w);
        return m;
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        exp_t e;
        if (scoreboard.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
            return;
        end
        e = scoreboard.pop_front();
        checkOutput({tag, "/w32"},  longint'($signed(acc0)), e.e0);
        checkOutput({tag, "/w16"},  longint'($signed(acc1)), e.e1);
        checkOutput({tag, "/sat"},  longint'($signed(acc2)), e.e2);
        checkOutput({tag, "/pipe"}, longint'($signed(acc3)), e.e3);
    endtask

    // Drives one operand pair, advances one edge, updates the model, then compares.
    task automatic applyStimulus(input bit en, input int ia, input int ib, input string tag);
        longint p;
        exp_t   e;
        enable = en;
        a      = 8'(ia);
        b      = 8'(ib);
        @(posedge clk);
        p = longint'(ia) * longint'(ib);
        if (en) begin
            m0 = fitAcc(m0 + p, 32, 1'b0);
            m1 = fitAcc(m1 + p, 16, 1'b0);
            m2 = fitAcc(m2 + p, 16, 1'b1);
        end
        if (pen) m3 = fitAcc(m3 + pprod, 32, 1'b0);
        pprod = p;
        pen   = en;
        e.e0 = m0; e.e1 = m1; e.e2 = m2; e.e3 = m3;
        scoreboard.push_back(e);
        #1;
        checkAll(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic pulseReset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        checkOutput({tag, "/w32"},  longint'($signed(acc0)), 0);
        checkOutput({tag, "/w16"},  longint'($signed(acc1)), 0);
        checkOutput({tag, "/sat"},  longint'($signed(acc2)), 0);
        checkOutput({tag, "/pipe"}, longint'($signed(acc3)), 0);
        m0 = 0; m1 = 0; m2 = 0; m3 = 0; pprod = 0; pen = 1'b0;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int tp1a[5] = '{0, -5, 1, 5, 2};
        int tp1b[5] = '{0, 5, 3, 4, 6};
        int tp1e[5] = '{0, -25, -22, -2, 10};
        tests = 0; failures = 0;
        m0 = 0; m1 = 0; m2 = 0; m3 = 0; pprod = 0; pen = 1'b0;
        reset = 1'b1; enable = 1'b1; a = '0; b = '0;
        #1;
        checkOutput("reset_w32",  longint'($signed(acc0)), 0);
        checkOutput("reset_pipe", longint'($signed(acc3)), 0);
        #9;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, tp1a[i], tp1b[i], "tp1");
            checkOutput("tp1_lit", longint'($signed(acc0)), longint'(tp1e[i]));
        end

        pulseReset("rst2");
        applyStimulus(1'b1, 3, 4, "tp2");
        checkOutput("tp2_12", longint'($signed(acc0)), 12);
        applyStimulus(1'b1, 3, 4, "tp2");
        checkOutput("tp2_24", longint'($signed(acc0)), 24);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 9, 9, "tp2_hold");
            checkOutput("tp2_hold", longint'($signed(acc0)), 24);
        end
        applyStimulus(1'b1, 1, 1, "tp2");
        checkOutput("tp2_25", longint'($signed(acc0)), 25);

        pulseReset("rst3");
        applyStimulus(1'b1, -5, 5, "tp3");
        checkOutput("tp3_m25", longint'($signed(acc0)), -25);
        pulseReset("rst3_mid");
        applyStimulus(1'b1, 2, 3, "tp3");
        checkOutput("tp3_6", longint'($signed(acc0)), 6);

        pulseReset("rst4");
        applyStimulus(1'b1, -128, -128, "tp4");
        checkOutput("tp4_16384", longint'($signed(acc0)), 16384);
        applyStimulus(1'b1, -128, 127, "tp4");
        checkOutput("tp4_128", longint'($signed(acc0)), 128);
        applyStimulus(1'b1, 127, 127, "tp4");
        checkOutput("tp4_16257", longint'($signed(acc0)), 16257);

        pulseReset("rst5");
        applyStimulus(1'b1, 127, 127, "tp5");
        applyStimulus(1'b1, 127, 127, "tp5");
        checkOutput("tp5_wrap2", longint'($signed(acc1)), 32258);
        applyStimulus(1'b1, 127, 127, "tp5");
        checkOutput("tp5_wrap3", longint'($signed(acc1)), -17149);
        checkOutput("tp5_sat3",  longint'($signed(acc2)), 32767);

        pulseReset("rst5n");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, -128, 127, "tp5n");
        checkOutput("tp5_satneg", longint'($signed(acc2)), -32768);
        applyStimulus(1'b1, 127, 127, "tp5n");
        checkOutput("tp5_recover", longint'($signed(acc2)), -16639);

        pulseReset("rst6");
        applyStimulus(1'b1, 5, 4, "tp6");
        checkOutput("tp6_edge1", longint'($signed(acc3)), 0);
        applyStimulus(1'b0, 7, 7, "tp6");
        checkOutput("tp6_edge2", longint'($signed(acc3)), 20);
        applyStimulus(1'b0, 7, 7, "tp6");
        checkOutput("tp6_hold", longint'($signed(acc3)), 20);

        pulseReset("rst6b");
        applyStimulus(1'b1, 5, 4, "tp6b");
        pulseReset("rst6b_mid");
        applyStimulus(1'b0, 7, 7, "tp6b");
        checkOutput("tp6b_flushed", longint'($signed(acc3)), 0);

        pulseReset("rst7");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(bit'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 255)) - 128, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
